poly_mul_stream_ctrl: RTL and testbench

- Streaming front-end/back-end sequencer for the 64×64 Saber-class polynomial multiplier memory wrapper.
- Accepts operand coefficients on a valid/ready input stream and writes them into the wrapper's A/B memories. Writing each slot also clears the matching result slot.
- Pulses the wrapper's start, waits for done, then streams the result coefficients out on a valid/ready output stream with last-beat marking.
- Sits directly upstream and downstream of the wrapper, driving its address, data_in, write_en and start ports and consuming data_out and done.

---
 rtl/poly_mul_pkg.sv | 18 +
 rtl/poly_mul_out_reg.sv | 34 +++
 rtl/poly_mul_stream_ctrl.sv | 118 +++++++++++
 tb/tb_poly_mul_stream_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_mul_pkg.sv
// Shared constants and sequencer state encoding for the poly_mul stream controller,
// also reusable by the multiplier wrapper test bench.
package poly_mul_pkg;

    localparam int N_A = 64;
    localparam int N_B = 64;
    localparam int N_C = 128;
    localparam int DW  = 16;
    localparam int AW  = 7;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_KICK  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } poly_mul_state_e;

endpackage

// File: rtl/poly_mul_out_reg.sv
// Single-entry output register with last flag; refills in the same cycle it drains,
// so sustained m_ready gives one beat per cycle.
module poly_mul_out_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last
);

    // A beat transfers on a rising edge where m_valid && m_ready; while m_valid is high
    // and m_ready is low, m_data/m_last/m_valid hold unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_data  <= load_data;
            m_valid <= 1'b1;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/poly_mul_stream_ctrl.sv
// Stream sequencer around the poly multiplier wrapper: loads A/B from the input stream,
// pulses start, waits for done, then streams the result slots out.
module poly_mul_stream_ctrl #(
    parameter int N_A = poly_mul_pkg::N_A,
    parameter int N_B = poly_mul_pkg::N_B,
    parameter int N_C = poly_mul_pkg::N_C,
    parameter int DW  = poly_mul_pkg::DW,
    parameter int AW  = poly_mul_pkg::AW
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DW-1:0]                 s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [DW-1:0]                 m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic [AW-1:0]                 mul_address,
    output logic [DW-1:0]                 mul_data_in,
    output logic                          mul_write_en,
    output logic                          mul_start,
    input  logic [DW-1:0]                 mul_data_out,
    input  logic                          mul_done,
    output logic                          busy,
    output logic                          frame_err,
    output poly_mul_pkg::poly_mul_state_e dbg_state
);
    import poly_mul_pkg::*;

    localparam logic [AW:0] WR_LAST = (AW+1)'(N_A + N_B - 1);
    localparam logic [AW:0] RD_LAST = (AW+1)'(N_C - 1);
    localparam logic [AW:0] RD_END  = (AW+1)'(N_C);

    poly_mul_state_e state, state_d;
    logic [AW:0]     wr_cnt;
    logic [AW:0]     rd_cnt;
    logic            rst_done;
    logic            s_hs;
    logic            load_en;

    assign s_hs      = s_valid && s_ready;
    assign busy      = !(state == ST_LOAD && wr_cnt == '0);
    assign dbg_state = state;

    // rst_done keeps s_ready low while resetn is asserted even though state sits in LOAD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_LOAD;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rst_done  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state    <= state_d;
            rst_done <= 1'b1;
            if (state == ST_LOAD && s_hs) begin
                if (s_last != (wr_cnt == WR_LAST))
                    frame_err <= 1'b1;
                wr_cnt <= (wr_cnt == WR_LAST) ? '0 : wr_cnt + 1'b1;
            end
            if (state == ST_WAIT && mul_done)
                rd_cnt <= '0;
            else if (load_en)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d      = state;
        s_ready      = 1'b0;
        mul_write_en = 1'b0;
        mul_address  = '0;
        mul_data_in  = '0;
        mul_start    = 1'b0;
        load_en      = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready      = rst_done;
                mul_write_en = s_valid && rst_done;
                mul_address  = wr_cnt[AW-1:0];
                mul_data_in  = s_data;
                // A fixed-length load: only the beat count ends it, never s_last.
                if (s_valid && rst_done && wr_cnt == WR_LAST)
                    state_d = ST_KICK;
            end
            ST_KICK: begin
                mul_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                mul_address = rd_cnt[AW-1:0];
                load_en     = (!m_valid || m_ready) && (rd_cnt < RD_END);
                if (m_valid && m_ready && m_last)
                    state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    poly_mul_out_reg #(.DW(DW)) u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load_en),
        .load_data (mul_data_out),
        .load_last (rd_cnt == RD_LAST),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last)
    );

endmodule

// File: tb/tb_poly_mul_stream_ctrl.sv
// Bench for poly_mul_stream_ctrl: a behavioural multiplier wrapper plus a product
// reference computed from the operands sent on the input stream.
module tb_poly_mul_stream_ctrl;
    import poly_mul_pkg::*;

    localparam int NAB = N_A + N_B;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_last;
    logic            m_ready = 1'b0;
    logic [AW-1:0]   mul_address;
    logic [DW-1:0]   mul_data_in;
    logic            mul_write_en;
    logic            mul_start;
    logic [DW-1:0]   mul_data_out;
    logic            mul_done;
    logic            busy;
    logic            frame_err;
    poly_mul_state_e dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0]    op[NAB];
    logic [DW-1:0]    exp_q[$];
    logic [DW-1:0]    got_q[$];
    logic [AW+DW-1:0] wr_log_q[$];
    int               start_cnt = 0;
    int               first_cyc, last_cyc;

    always #5 clk = ~clk;

    poly_mul_stream_ctrl dut (
        .clk(clk), .resetn(resetn),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .mul_address(mul_address), .mul_data_in(mul_data_in), .mul_write_en(mul_write_en),
        .mul_start(mul_start), .mul_data_out(mul_data_out), .mul_done(mul_done),
        .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state)
    );

    // ---------------- behavioural multiplier wrapper ----------------
    logic [DW-1:0] a_mem[N_A];
    logic [DW-1:0] b_mem[N_B];
    logic [DW-1:0] c_mem[N_C];
    logic          model_done;
    logic          inj_done = 1'b0;
    logic          computing;
    int            done_cd;

    assign mul_done     = model_done | inj_done;
    assign mul_data_out = c_mem[mul_address];

    function automatic logic [DW-1:0] model_coef(input int k);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < N_A; i++)
            if (k - i >= 0 && k - i < N_B)
                s = s + a_mem[i] * b_mem[k-i];
        return s;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            computing  <= 1'b0;
            model_done <= 1'b0;
            done_cd    <= 0;
        end else begin
            model_done <= 1'b0;
            if (mul_write_en) begin
                if (int'(mul_address) < N_A) a_mem[mul_address] <= mul_data_in;
                else                         b_mem[int'(mul_address) - N_A] <= mul_data_in;
                c_mem[mul_address] <= '0;
            end
            if (mul_start) begin
                computing <= 1'b1;
                done_cd   <= $urandom_range(3, 20);
            end else if (computing) begin
                if (done_cd == 0) begin
                    computing  <= 1'b0;
                    model_done <= 1'b1;
                    for (int k = 0; k < N_C; k++)
                        c_mem[k] <= c_mem[k] + model_coef(k);
                end else begin
                    done_cd <= done_cd - 1;
                end
            end
        end
    end

    // Interface log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mul_write_en) wr_log_q.push_back({mul_address, mul_data_in});
        if (mul_start) start_cnt++;
    end

    // ---------------- reference: plain polynomial product of the sent operands ----------------
    function automatic logic [DW-1:0] ref_coef(input int k);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < N_A; i++)
            for (int j = 0; j < N_B; j++)
                if (i + j == k) s = s + op[i] * op[N_A + j];
        return s;
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int k = 0; k < N_C; k++) exp_q.push_back(ref_coef(k));
    endtask

    task automatic fill_random();
        for (int i = 0; i < NAB; i++) op[i] = DW'($urandom_range(0, 65535));
    endtask

    // ---------------- drivers ----------------
    task automatic load_frame(input int last_pos, input int gap_pct);
        int i = 0;
        int guard = 0;
        wr_log_q.delete();
        start_cnt = 0;
        while (i < NAB && guard < 3000) begin
            @(posedge clk); #1;
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = op[i];
            s_last  = s_valid && (i == last_pos);
            @(negedge clk);
            if (s_valid && s_ready) i++;
            guard++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        vectors++;
        if (i != NAB) begin
            miscompares++;
            $display("FAIL load_timeout: accepted %0d beats, want %0d", i, NAB);
        end
    endtask

    task automatic check_writes();
        vectors++;
        if (wr_log_q.size() != NAB) begin
            miscompares++;
            $display("FAIL write_count: got %0d write_en pulses, want %0d", wr_log_q.size(), NAB);
        end else begin
            for (int k = 0; k < NAB; k++) begin
                vectors++;
                if (wr_log_q[k] !== {AW'(k), op[k]}) begin
                    miscompares++;
                    $display("FAIL write_beat %0d: got addr %0d data %h, want addr %0d data %h",
                             k, wr_log_q[k][AW+DW-1:DW], wr_log_q[k][DW-1:0], k, op[k]);
                end
            end
        end
    endtask

    // Returns early (before the final acceptance edge) once abort_at beats are committed.
    task automatic drain_frame(input int ready_pct, input int abort_at);
        int cyc = 0;
        bit stall = 1'b0;
        bit fin = 1'b0;
        logic [DW-1:0] sd = '0;
        logic sl = 1'b0;
        got_q.delete();
        first_cyc = -1;
        last_cyc  = -1;
        while (!fin && cyc < 3000) begin
            @(posedge clk); #1;
            m_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            cyc++;
            if (stall) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== sd || m_last !== sl) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             m_valid, m_data, m_last, sd, sl);
                end
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (m_last !== (got_q.size() == N_C - 1)) begin
                    miscompares++;
                    $display("FAIL last_flag beat %0d: got %b, want %b",
                             got_q.size(), m_last, got_q.size() == N_C - 1);
                end
                got_q.push_back(m_data);
                if (got_q.size() == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (m_last) fin = 1'b1;
                if (abort_at > 0 && got_q.size() == abort_at) fin = 1'b1;
            end
            stall = m_valid && !m_ready;
            sd = m_data;
            sl = m_last;
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats, want %0d", got_q.size(), N_C);
        end
        if (abort_at == 0) begin
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
    endtask

    task automatic check_result();
        logic [DW-1:0] e;
        vectors++;
        if (got_q.size() != N_C) begin
            miscompares++;
            $display("FAIL beat_count: got %0d beats, want %0d", got_q.size(), N_C);
        end else begin
            for (int k = 0; k < N_C; k++) begin
                e = exp_q.pop_front();
                vectors++;
                if (got_q[k] !== e) begin
                    miscompares++;
                    $display("FAIL result_beat %0d: got %h, want %h", k, got_q[k], e);
                end
            end
        end
    endtask

    task automatic full_frame(input int gap_pct, input int ready_pct);
        build_exp();
        load_frame(NAB - 1, gap_pct);
        check_writes();
        drain_frame(ready_pct, 0);
        check_result();
        vectors++;
        if (start_cnt != 1) begin
            miscompares++;
            $display("FAIL start_pulses: got %0d, want 1", start_cnt);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        vectors++;
        if ({s_ready, m_valid, m_last, mul_start, mul_write_en, frame_err, busy} !== 7'b0 ||
            m_data !== '0 || mul_address !== '0 || dbg_state !== ST_LOAD) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b mv=%b ml=%b st=%b we=%b fe=%b busy=%b md=%h addr=%0d state=%0d, want all 0 / LOAD",
                     tag, s_ready, m_valid, m_last, mul_start, mul_write_en, frame_err, busy,
                     m_data, mul_address, dbg_state);
        end
    endtask

    task automatic watch_no_output(input string tag, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (m_valid || dbg_state != ST_LOAD) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL %s: got %0d cycles with m_valid or non-LOAD state, want 0", tag, seen);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn  = 1'b0;
        s_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_reset("reset_values");
        s_valid = 1'b0;
        resetn  = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_ready: got s_ready=%b busy=%b, want 1/0", s_ready, busy);
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < N_A; i++) op[i] = 16'd1;
        for (int i = N_A; i < NAB; i++) op[i] = 16'd2;
        build_exp();
        load_frame(NAB - 1, 0);
        vectors++;
        if (dbg_state !== ST_KICK || mul_start !== 1'b1 || busy !== 1'b1 || mul_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL kick_cycle: got state=%0d start=%b busy=%b we=%b, want KICK/1/1/0",
                     dbg_state, mul_start, busy, mul_write_en);
        end
        check_writes();
        drain_frame(100, 0);
        check_result();
        vectors++;
        if (start_cnt != 1) begin
            miscompares++;
            $display("FAIL start_pulses: got %0d, want 1", start_cnt);
        end
        vectors++;
        if (last_cyc - first_cyc != N_C - 1) begin
            miscompares++;
            $display("FAIL streaming_rate: got %0d cycles first..last, want %0d", last_cyc - first_cyc, N_C - 1);
        end
        vectors++;
        if (frame_err !== 1'b0 || dbg_state !== ST_LOAD || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end: got fe=%b state=%0d mv=%b, want 0/LOAD/0", frame_err, dbg_state, m_valid);
        end
    endtask

    task automatic test_single_term();
        for (int i = 0; i < NAB; i++) op[i] = '0;
        op[0]   = 16'd3;
        op[N_A] = 16'd5;
        full_frame(30, 100);
        vectors++;
        if (got_q.size() == 0 || got_q[0] !== 16'd15) begin
            miscompares++;
            $display("FAIL single_term_beat0: got %h, want %h", got_q.size() ? got_q[0] : 16'hxxxx, 16'd15);
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        full_frame(20, 50);
    endtask

    task automatic test_frame_err();
        fill_random();
        build_exp();
        load_frame(60, 0);
        vectors++;
        if (frame_err !== 1'b1 || dbg_state !== ST_KICK) begin
            miscompares++;
            $display("FAIL frame_err_set: got fe=%b state=%0d, want 1/KICK", frame_err, dbg_state);
        end
        check_writes();
        drain_frame(100, 0);
        check_result();
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_err_sticky: got %b, want 1", frame_err);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        fill_random();
        load_frame(NAB - 1, 0);
        while (dbg_state != ST_WAIT && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (dbg_state != ST_WAIT) begin
            miscompares++;
            $display("FAIL reach_wait: got state %0d, want WAIT", dbg_state);
        end
        resetn = 1'b0;
        #1;
        check_idle_reset("reset_in_wait");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        watch_no_output("quiet_after_wait_reset", 40);

        fill_random();
        load_frame(NAB - 1, 0);
        drain_frame(100, 40);
        @(posedge clk); #1;
        resetn  = 1'b0;
        m_ready = 1'b0;
        #1;
        check_idle_reset("reset_in_drain");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        watch_no_output("quiet_after_drain_reset", 40);

        fill_random();
        full_frame(10, 70);
    endtask

    task automatic test_done_in_load();
        @(posedge clk); #1;
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        @(negedge clk);
        vectors++;
        if (dbg_state !== ST_LOAD || m_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_in_load: got state=%0d mv=%b busy=%b, want LOAD/0/0", dbg_state, m_valid, busy);
        end
        watch_no_output("quiet_after_stray_done", 20);
        fill_random();
        full_frame(0, 100);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_term();
        test_backpressure();
        test_frame_err();
        test_reset_mid();
        test_done_in_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
